timer_dev: RTL

Memory-mapped 32-bit countdown timer that responds to M-stage data accesses from the pipelined `mips` core, the target side of the core's store/load port. The core's address decode selects this device in place of `dm`. Reads return register contents combinationally for capture in the W-stage register; writes commit on the clock edge. A down-counter state machine raises an interrupt request when the count expires.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_dev.sv | 124 ++++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM encoding,
// register offsets and CTRL field layout.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_MODE = 1;
   localparam int unsigned CTRL_IM   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Only 01 reloads; both 1x encodings behave as one-shot.
   function automatic logic is_reload(input logic [1:0] mode);
      return mode == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// 32-bit countdown timer on the core's M-stage data port.
// Define TIMER_IRQ_EN to build the IM bit, pending flag and irq output.
module timer_dev
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   state_t      state;
   logic        en;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count;
   logic [31:0] ctrl_word;
   logic        wr_ctrl;
   logic        wr_preset;

`ifdef TIMER_IRQ_EN
   logic pending;
`endif

   always_comb begin
      wr_ctrl   = sel && we && (addr == REG_CTRL);
      wr_preset = sel && we && (addr == REG_PRESET);
   end

   // FSM reads the pre-write register values; CPU writes are applied last so
   // they win over any FSM update of the same register on that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         en     <= 1'b0;
         mode   <= MODE_ONESHOT;
         preset <= '0;
         count  <= '0;
`ifdef TIMER_IRQ_EN
         im      <= 1'b0;
         pending <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (en) state <= ST_LOAD;
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!en) begin
                  state <= ST_IDLE;
               end else if (count <= 32'd1) begin
                  count <= '0;
                  state <= ST_INT;
`ifdef TIMER_IRQ_EN
                  pending <= 1'b1;
`endif
               end else begin
                  count <= count - 32'd1;
               end
            end
            ST_INT: begin
               if (is_reload(mode)) begin
                  state <= ST_LOAD;
`ifdef TIMER_IRQ_EN
                  pending <= 1'b0;
`endif
               end else begin
                  en    <= 1'b0;
                  state <= ST_IDLE;
               end
            end
         endcase

         if (wr_ctrl) begin
            en   <= wdata[CTRL_EN];
            mode <= wdata[CTRL_MODE +: 2];
`ifdef TIMER_IRQ_EN
            im      <= wdata[CTRL_IM];
            pending <= 1'b0;
`endif
         end

         if (wr_preset) begin
            preset <= wdata;
`ifdef TIMER_IRQ_EN
            pending <= 1'b0;
`endif
         end
      end
   end

`ifdef TIMER_IRQ_EN
   always_comb irq = pending & im;
`else
   always_comb im  = 1'b0;
   always_comb irq = 1'b0;
`endif

   always_comb begin
      ctrl_word                   = '0;
      ctrl_word[CTRL_EN]          = en;
      ctrl_word[CTRL_MODE +: 2]   = mode;
      ctrl_word[CTRL_IM]          = im;
      rdata                       = '0;
      if (sel) begin
         case (addr)
            REG_CTRL:   rdata = ctrl_word;
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = '0;
         endcase
      end
   end

endmodule
